// File: rtl/serial_sub_16bit_pkg.sv
// Shared constants and FSM state type for the nibble-serial 16-bit subtractor.
package serial_sub_16bit_pkg;

  localparam int WORD_W      = 16;
  localparam int NIBBLE_W    = 4;
  localparam int NUM_NIBBLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_slice_4bit.sv
// 4-bit subtract slice: a + ~b + cin with a carry-lookahead carry chain.
module sub_slice_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] bn;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  // Every carry is flattened from generate/propagate terms, so no carry ripples.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/serial_sub_16bit.sv
// Nibble-serial 16-bit subtractor: one 4-bit slice reused over four cycles, LSB first,
// with a valid/ready handshake on both sides.
module serial_sub_16bit
  import serial_sub_16bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] X,
  input  logic [WORD_W-1:0] Y,
  input  logic              BIN,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] D,
  output logic              BOUT,
  output logic              OVF,
  output logic              ZERO
);

  state_t              state;
  state_t              next_state;
  logic [WORD_W-1:0]   x_op;
  logic [WORD_W-1:0]   y_op;
  logic [WORD_W-1:0]   diff;
  logic                carry;
  logic [1:0]          k;
  logic                bout_flag;
  logic                ovf_flag;
  logic                zero_flag;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  sub_slice_4bit u_slice (
    .a    (x_op[{k, 2'b00} +: NIBBLE_W]),
    .b    (y_op[{k, 2'b00} +: NIBBLE_W]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = in_valid ? RUN : IDLE;
      RUN:     next_state = (k == 2'd3) ? DONE : RUN;
      DONE:    next_state = out_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Status flags are captured on the last nibble so they read 0 outside DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_op      <= 16'h0000;
      y_op      <= 16'h0000;
      diff      <= 16'h0000;
      carry     <= 1'b0;
      k         <= 2'd0;
      bout_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_op  <= X;
            y_op  <= Y;
            carry <= ~BIN;
            k     <= 2'd0;
            diff  <= 16'h0000;
          end
        end
        RUN: begin
          diff[{k, 2'b00} +: NIBBLE_W] <= slice_s;
          carry <= slice_cout;
          k     <= k + 2'd1;
          if (k == 2'd3) begin
            bout_flag <= ~slice_cout;
            ovf_flag  <= (x_op[15] != y_op[15]) & (slice_s[3] != x_op[15]);
            zero_flag <= (diff[11:0] == 12'h000) & (slice_s == 4'h0);
          end
        end
        DONE: begin
          if (out_ready) begin
            bout_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            zero_flag <= 1'b0;
          end
        end
        default: begin
          k <= 2'd0;
        end
      endcase
    end
  end

  assign D    = diff;
  assign BOUT = bout_flag;
  assign OVF  = ovf_flag;
  assign ZERO = zero_flag;

endmodule

// File: tb/tb_serial_sub_16bit.sv
// Self-checking bench for serial_sub_16bit: directed and random operands against an arithmetic model.
module tb_serial_sub_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] X = 16'h0000;
  logic [15:0] Y = 16'h0000;
  logic        BIN = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] D;
  logic        BOUT;
  logic        OVF;
  logic        ZERO;

  int n_assert = 0;
  int n_fail   = 0;

  serial_sub_16bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .BIN(BIN), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .BOUT(BOUT), .OVF(OVF), .ZERO(ZERO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {bout, ovf, zero, d} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic b);
    int ux, uy, sx, sy, sd;
    logic [15:0] d;
    logic bo, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    sd = sx - sy - int'(b);
    d  = 16'(ux - uy - int'(b));
    bo = (ux < uy + int'(b));
    ov = (sd > 32767) || (sd < -32768);
    return {bo, ov, (d == 16'h0000), d};
  endfunction

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      check({tag, "_flags_pre"}, {29'd0, BOUT, OVF, ZERO}, 32'd0);
      step();
      cnt++;
    end
    check({tag, "_latency"}, cnt, 32'd4);
  endtask

  task automatic check_result(input string tag, input logic [15:0] x, input logic [15:0] y, input logic b);
    logic [18:0] m;
    m = model(x, y, b);
    check({tag, "_D"},    {16'd0, D}, {16'd0, m[15:0]});
    check({tag, "_BOUT"}, {31'd0, BOUT}, {31'd0, m[18]});
    check({tag, "_OVF"},  {31'd0, OVF},  {31'd0, m[17]});
    check({tag, "_ZERO"}, {31'd0, ZERO}, {31'd0, m[16]});
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic b);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; X = x; Y = y; BIN = b;
    step();
    in_valid = 1'b0; X = 16'($urandom); Y = 16'($urandom); BIN = 1'($urandom);
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_done(tag);
    check_result(tag, x, y, b);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_release"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic        rb;
    logic [18:0] m;

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out", {13'd0, out_valid, BOUT, OVF, ZERO, 16'h0000}, {16'd0, D});

    // Directed vectors and fixed-result edge cases
    run_op("v1234", 16'h1234, 16'h0234, 1'b0);
    check("v1234_exactD", {16'd0, D}, 32'h1000);
    run_op("v0001", 16'h0000, 16'h0001, 1'b0);
    run_op("v8000", 16'h8000, 16'h0001, 1'b0);
    run_op("v5555", 16'h5555, 16'h5554, 1'b1);
    run_op("y_zero", 16'hBEEF, 16'h0000, 1'b0);
    run_op("x_eq_y", 16'hA5A5, 16'hA5A5, 1'b0);
    run_op("wrap", 16'h0000, 16'hFFFF, 1'b1);
    run_op("neg_ovf", 16'h7FFF, 16'hFFFF, 1'b0);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      rx = 16'($urandom);
      ry = (i % 6 == 0) ? rx : 16'($urandom);
      rb = 1'($urandom);
      run_op("rand", rx, ry, rb);
    end

    // Backpressure: results hold and new operands are ignored while DONE
    in_valid = 1'b1; X = 16'h9000; Y = 16'h1001; BIN = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done("bp");
    X = 16'h0F0F; Y = 16'h0101; BIN = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", {30'd0, in_ready, out_valid}, 32'd1);
      check_result("bp_hold", 16'h9000, 16'h1001, 1'b1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle", {30'd0, in_ready, out_valid}, 32'd2);
    step();
    in_valid = 1'b0;
    check("bp_accepted", {31'd0, in_ready}, 32'd0);
    wait_done("bp_new");
    check_result("bp_new", 16'h0F0F, 16'h0101, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during RUN at k=2 aborts the operation
    in_valid = 1'b1; X = 16'h4321; Y = 16'h1234; BIN = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", {30'd0, in_ready, out_valid}, 32'd2);
    check("abort_D", {16'd0, D}, 32'd0);
    check("abort_flags", {29'd0, BOUT, OVF, ZERO}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    run_op("post_abort", 16'h00FF, 16'h000F, 1'b0);
    m = model(16'h00FF, 16'h000F, 1'b0);
    check("post_abort_model", {16'd0, m[15:0]}, 32'h00F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_sub_16bit.md
SERIAL_SUB_16BIT -- requirements
Module: serial_sub_16bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by package constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands X, Y and BIN valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 X  input  16  minuend.
REQ-007 Y  input  16  subtrahend.
REQ-008 BIN  input  1  borrow in.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 D  output  16  difference, X - Y - BIN mod 2^16.
REQ-012 BOUT  output  1  borrow out; 1 when unsigned X < Y + BIN.
REQ-013 OVF  output  1  two's-complement overflow.
REQ-014 ZERO  output  1  D == 0.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 Accept: in IDLE with in_valid=1, the block SHALL latch X, Y, set carry = ~BIN, clear the nibble index k and the D register, and enter RUN.
REQ-017 RUN: each cycle, the block SHALL compute X[4k+3:4k] + ~Y[4k+3:4k] + carry in one 4-bit lookahead slice, write the 4-bit sum into D[4k+3:4k], and register the slice carry-out.
REQ-018 RUN SHALL take nibbles LSB first, k = 0,1,2,3, and SHALL go to DONE after the k=3 cycle.
REQ-019 Latency: out_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-020 In DONE: BOUT = ~final carry; OVF = (X[15] != Y[15]) & (D[15] != X[15]); ZERO = (D == 16'h0000).
REQ-021 D, BOUT, OVF and ZERO SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-022 DONE with out_ready=1 SHALL go to IDLE on the next edge; there is no same-cycle re-accept, so throughput is at most one operation per 6 cycles.
REQ-023 in_valid, X, Y and BIN SHALL be ignored in RUN and DONE.
REQ-024 Before DONE, the BOUT, OVF and ZERO outputs SHALL read 0.
REQ-025 Edge cases with fixed results:
- Y=0, BIN=0 -> D=X, BOUT=0.
- X=Y, BIN=0 -> ZERO=1.
- 0x0000 - 0xFFFF - 1 -> D=0x0000, BOUT=1.

Reset
REQ-026 On rst=1 at any edge, including mid-RUN or in DONE, the block SHALL enter IDLE.
REQ-027 The same reset SHALL clear D, BOUT, OVF, ZERO, carry, k and the operand registers to 0, and drive out_valid=0.
REQ-028 in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-029 An aborted operation SHALL produce no result.

Structure
REQ-030 The shared package SHALL hold:
- WORD_W=16, NIBBLE_W=4, NUM_NIBBLES=4;
- the FSM state typedef (IDLE, RUN, DONE).
REQ-031 A sub-module sub_slice_4bit SHALL contain the 4-bit slice: inputs a[3:0], b[3:0], cin; outputs s[3:0], cout; it inverts b internally and uses carry-lookahead.
REQ-032 serial_sub_16bit SHALL instantiate one sub_slice_4bit, and operand nibbles SHALL be selected by k.

Verification
REQ-033 X=0x1234, Y=0x0234, BIN=0 -> D=0x1000, BOUT=0, OVF=0, ZERO=0; out_valid 4 edges after accept.
REQ-034 X=0x0000, Y=0x0001, BIN=0 -> D=0xFFFF, BOUT=1, OVF=0, ZERO=0.
REQ-035 X=0x8000, Y=0x0001, BIN=0 -> D=0x7FFF, OVF=1, BOUT=0.
REQ-036 X=0x5555, Y=0x5554, BIN=1 -> D=0x0000, ZERO=1, BOUT=0, OVF=0.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> outputs unchanged and in_ready=0; after out_ready=1, IDLE then the new operands are accepted.
REQ-038 Assert rst at RUN k=2 -> next cycle state IDLE, out_valid=0, in_ready=1, D=0; the following operation 0x00FF - 0x000F -> D=0x00F0.
